// File: rtl/idu0_q_pkg.sv
// idu0_q_pkg -- shared decode types and widths for the IDU0 decoded-entry queue.
// Rev 1.0 -- initial release.
`default_nettype none
package idu0_q_pkg;

   localparam int INSTR_LEN = 32;
   localparam int XLEN      = 32;

   typedef struct packed {
      logic lui;
      logic auipc;
      logic jal;
      logic jalr;
      logic condbr;
      logic load;
      logic store;
      logic alu;
      logic shift;
      logic imm12;
      logic imm20;
      logic pc;
      logic rs1_en;
      logic rs2_en;
      logic rd_en;
      logic fence;
      logic system;
      logic legal;
   } decode_out_t;

   typedef struct packed {
      logic [INSTR_LEN-1:0] instr;
      logic [XLEN-1:0]      tag;
      logic [4:0]           rs1_addr;
      logic [4:0]           rs2_addr;
      logic [4:0]           rd_addr;
      logic [4:0]           shamt;
      logic [31:0]          imm;
      logic                 imm_valid;
      decode_out_t          dec;
      logic                 legal;
   } idu0_out_t;

endpackage
`default_nettype wire

// File: rtl/idu0_q_decode.sv
// idu0_q_decode -- combinational RV32I opcode classifier producing decode_out_t flags.
// Rev 1.0 -- initial release.
`default_nettype none
module idu0_q_decode
   import idu0_q_pkg::*;
(
   input  logic [INSTR_LEN-1:0] instr_i,
   output decode_out_t          dec_o
);

   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;

   assign op = instr_i[6:0];
   assign f3 = instr_i[14:12];
   assign f7 = instr_i[31:25];

   always_comb begin
      dec_o = '0;
      if (instr_i[1:0] == 2'b11) begin
         unique case (op)
            7'b0110111: begin
               dec_o.lui = 1'b1; dec_o.imm20 = 1'b1; dec_o.rd_en = 1'b1; dec_o.legal = 1'b1;
            end
            7'b0010111: begin
               dec_o.auipc = 1'b1; dec_o.imm20 = 1'b1; dec_o.rd_en = 1'b1; dec_o.legal = 1'b1;
            end
            7'b1101111: begin
               dec_o.jal = 1'b1; dec_o.imm20 = 1'b1; dec_o.pc = 1'b1;
               dec_o.rd_en = 1'b1; dec_o.legal = 1'b1;
            end
            7'b1100111: begin
               dec_o.jalr = 1'b1; dec_o.imm12 = 1'b1; dec_o.rs1_en = 1'b1;
               dec_o.rd_en = 1'b1; dec_o.legal = (f3 == 3'd0);
            end
            7'b1100011: begin
               dec_o.condbr = 1'b1; dec_o.rs1_en = 1'b1; dec_o.rs2_en = 1'b1;
               dec_o.legal = (f3 != 3'd2) && (f3 != 3'd3);
            end
            7'b0000011: begin
               dec_o.load = 1'b1; dec_o.rs1_en = 1'b1; dec_o.rd_en = 1'b1;
               dec_o.legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            end
            7'b0100011: begin
               dec_o.store = 1'b1; dec_o.rs1_en = 1'b1; dec_o.rs2_en = 1'b1;
               dec_o.legal = (f3 < 3'd3);
            end
            7'b0010011: begin
               dec_o.alu = 1'b1; dec_o.imm12 = 1'b1; dec_o.rs1_en = 1'b1; dec_o.rd_en = 1'b1;
               dec_o.shift = (f3 == 3'd1) || (f3 == 3'd5);
               // Immediate shifts reuse funct7 as an encoding check.
               if (f3 == 3'd1)      dec_o.legal = (f7 == 7'h00);
               else if (f3 == 3'd5) dec_o.legal = (f7 == 7'h00) || (f7 == 7'h20);
               else                 dec_o.legal = 1'b1;
            end
            7'b0110011: begin
               dec_o.alu = 1'b1; dec_o.rs1_en = 1'b1; dec_o.rs2_en = 1'b1; dec_o.rd_en = 1'b1;
               dec_o.shift = (f3 == 3'd1) || (f3 == 3'd5);
               dec_o.legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
            end
            7'b0001111: begin
               dec_o.fence = 1'b1; dec_o.legal = 1'b1;
            end
            7'b1110011: begin
               dec_o.system = 1'b1; dec_o.legal = 1'b1;
            end
            default: dec_o = '0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/idu0_q.sv
// idu0_q -- decodes IFU instructions and buffers the records in a DEPTH-entry FIFO for IDU1.
// Rev 1.0 -- optional IDU0_Q_PERF_CNT_EN adds perf_decoded / perf_stall counters.
`default_nettype none
module idu0_q
   import idu0_q_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [INSTR_LEN-1:0]           instr,
   input  logic                           instr_valid,
   input  logic [XLEN-1:0]                instr_tag,
   output logic                           instr_ready,
   input  logic                           pipe_flush,
   output logic [$bits(idu0_out_t)-1:0]   idu0_out,
   output logic                           idu0_out_valid,
   input  logic                           idu1_ready,
   output logic [$clog2(DEPTH+1)-1:0]     count
`ifdef IDU0_Q_PERF_CNT_EN
   ,
   output logic [31:0]                    perf_decoded,
   output logic [31:0]                    perf_stall
`endif
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   decode_out_t     dec;
   idu0_out_t       entry;
   idu0_out_t       mem_q [DEPTH];
   logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push, pop;

   idu0_q_decode u_decode (
      .instr_i (instr),
      .dec_o   (dec)
   );

   always_comb begin
      entry           = '0;
      entry.instr     = instr;
      entry.tag       = instr_tag;
      entry.rs1_addr  = instr[19:15];
      entry.rs2_addr  = instr[24:20];
      entry.rd_addr   = instr[11:7];
      entry.shamt     = instr[24:20];
      entry.dec       = dec;
      entry.legal     = dec.legal;
      entry.imm_valid = (dec.imm20 & ~dec.jal) | dec.imm12 | dec.condbr | dec.load | dec.store;
      if (dec.imm20 & ~dec.pc)
         entry.imm = {instr[31:12], 12'b0};
      else if (dec.imm20 & dec.pc)
         entry.imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      else if (dec.imm12 | dec.load)
         entry.imm = {{20{instr[31]}}, instr[31:20]};
      else if (dec.condbr)
         entry.imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      else if (dec.store)
         entry.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      else
         entry.imm = '0;
   end

   assign instr_ready    = (count_q < CW'(DEPTH));
   assign idu0_out_valid = (count_q != '0);
   assign count          = count_q;
   assign idu0_out       = idu0_out_valid ? mem_q[rptr_q] : '0;

   // Flush wins over any same-cycle push or pop.
   assign push = instr_valid & instr_ready & ~pipe_flush;
   assign pop  = idu0_out_valid & idu1_ready & ~pipe_flush;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (pipe_flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + 1'b1;
         if (pop)  rptr_d = rptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= entry;
   end

`ifdef IDU0_Q_PERF_CNT_EN
   logic [31:0] perf_decoded_q, perf_stall_q;
   logic        stall;

   assign stall        = instr_valid & ~instr_ready;
   assign perf_decoded = perf_decoded_q;
   assign perf_stall   = perf_stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_decoded_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         if (push && (perf_decoded_q != 32'hFFFF_FFFF)) perf_decoded_q <= perf_decoded_q + 32'd1;
         if (stall && (perf_stall_q != 32'hFFFF_FFFF))  perf_stall_q   <= perf_stall_q + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_idu0_q.sv
// tb_idu0_q -- scoreboard bench for idu0_q with directed instruction vectors.
`default_nettype none
module tb_idu0_q;
   import idu0_q_pkg::*;

   localparam int DEPTH = 4;

   logic                          clk = 1'b0;
   logic                          rst = 1'b1;
   logic [INSTR_LEN-1:0]          instr = '0;
   logic                          instr_valid = 1'b0;
   logic [XLEN-1:0]               instr_tag = '0;
   logic                          instr_ready;
   logic                          pipe_flush = 1'b0;
   logic [$bits(idu0_out_t)-1:0]  idu0_out;
   logic                          idu0_out_valid;
   logic                          idu1_ready = 1'b0;
   logic [$clog2(DEPTH+1)-1:0]    count;
`ifdef IDU0_Q_PERF_CNT_EN
   logic [31:0] perf_decoded, perf_stall;
`endif

   idu0_q #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .instr          (instr),
      .instr_valid    (instr_valid),
      .instr_tag      (instr_tag),
      .instr_ready    (instr_ready),
      .pipe_flush     (pipe_flush),
      .idu0_out       (idu0_out),
      .idu0_out_valid (idu0_out_valid),
      .idu1_ready     (idu1_ready),
      .count          (count)
`ifdef IDU0_Q_PERF_CNT_EN
      ,
      .perf_decoded   (perf_decoded),
      .perf_stall     (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] tag;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        iv;
      logic        legal;
   } exp_t;

   exp_t      sb[$];
   int        checks = 0;
   int        errors = 0;
   idu0_out_t o;
   assign o = idu0_out;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] addi(input int rd, input int imm);
      logic [11:0] i12;
      logic [4:0]  r5;
      i12 = imm[11:0];
      r5  = rd[4:0];
      return {i12, 5'd0, 3'd0, r5, 7'h13};
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [31:0] tag, input logic [31:0] imm,
                        input logic [4:0] rd, input logic iv, input logic legal);
      exp_t e;
      instr       = ins;
      instr_tag   = tag;
      instr_valid = 1'b1;
      e.instr = ins; e.tag = tag; e.imm = imm; e.rd = rd; e.iv = iv; e.legal = legal;
      sb.push_back(e);
   endtask

   task automatic drive_addi(input int rd, input int imm);
      drive(addi(rd, imm), 32'h1000 + 32'(rd * 4), 32'(imm), 5'(rd), 1'b1, 1'b1);
   endtask

   always @(negedge clk) begin
      if (!rst && !pipe_flush) begin
         if (idu0_out_valid && idu1_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got instr 0x%0h expected none", o.instr);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_instr", 64'(o.instr), 64'(e.instr));
               chk("out_tag", 64'(o.tag), 64'(e.tag));
               chk("out_rd", 64'(o.rd_addr), 64'(e.rd));
               chk("out_imm", 64'(o.imm), 64'(e.imm));
               chk("out_imm_valid", 64'(o.imm_valid), 64'(e.iv));
               chk("out_legal", 64'(o.legal), 64'(e.legal));
            end
         end else if (!idu0_out_valid) begin
            chk("zero_when_invalid", 64'(idu0_out == '0), 64'd1);
         end
      end
   end

   initial begin
      #22;
      rst = 1'b0;
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_valid", 64'(idu0_out_valid), 64'd0);
      chk("reset_ready", 64'(instr_ready), 64'd1);
      step();

      // addi x1,x0,5: visible one cycle after the push
      drive_addi(1, 5);
      step();
      instr_valid = 1'b0;
      chk("addi_valid", 64'(idu0_out_valid), 64'd1);
      chk("addi_count", 64'(count), 64'd1);
      chk("addi_rd", 64'(o.rd_addr), 64'd1);
      chk("addi_imm", 64'(o.imm), 64'd5);
      chk("addi_imm_valid", 64'(o.imm_valid), 64'd1);
      idu1_ready = 1'b1;
      step();

      // jal, beq, and an illegal word streamed through
      drive(32'h0080006F, 32'h2000, 32'h00000008, 5'd0, 1'b0, 1'b1);
      step();
      drive(32'hFE000EE3, 32'h2004, 32'hFFFFFFFC, 5'd29, 1'b1, 1'b1);
      step();
      drive(32'hFFFFFFFF, 32'h2008, 32'h00000000, 5'd31, 1'b0, 1'b0);
      step();
      instr_valid = 1'b0;
      step();
      step();
      chk("stream_count", 64'(count), 64'd0);

      // fill to DEPTH with consumer stalled, fifth held
      idu1_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_addi(i + 2, 16 + i);
         chk("fill_ready", 64'(instr_ready), 64'd1);
         step();
      end
      chk("full_count", 64'(count), 64'd4);
      chk("full_ready", 64'(instr_ready), 64'd0);
      instr = addi(7, 99);
      instr_tag = 32'h1000 + 32'd28;
      step();
      step();
      chk("held_count", 64'(count), 64'd4);
      chk("held_ready", 64'(instr_ready), 64'd0);
      idu1_ready = 1'b1;
      step();
      chk("pop_from_full_count", 64'(count), 64'd3);
      chk("fifth_ready", 64'(instr_ready), 64'd1);
      drive_addi(7, 99);
      step();
      chk("fifth_accept_count", 64'(count), 64'd3);
      instr_valid = 1'b0;
      step();
      step();
      step();
      chk("drain_count", 64'(count), 64'd0);

      // count=3 with simultaneous push and pop for 10 cycles
      idu1_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_addi(10 + i, 32 + i);
         step();
      end
      chk("pre_sim_count", 64'(count), 64'd3);
      idu1_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_addi(13 + i, 40 + i);
         step();
         chk("sim_count", 64'(count), 64'd3);
      end
      instr_valid = 1'b0;
      step();
      step();
      step();
      chk("sim_drain_count", 64'(count), 64'd0);

      // flush at count=3 with an incoming instruction
      idu1_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_addi(23 + i, 64 + i);
         step();
      end
      chk("pre_flush_count", 64'(count), 64'd3);
      instr = addi(26, 8'h77);
      instr_valid = 1'b1;
      pipe_flush = 1'b1;
      step();
      pipe_flush = 1'b0;
      instr_valid = 1'b0;
      sb.delete();
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(idu0_out_valid), 64'd0);
      chk("flush_out_zero", 64'(idu0_out == '0), 64'd1);
      drive_addi(27, 8'h55);
      step();
      instr_valid = 1'b0;
      chk("post_flush_count", 64'(count), 64'd1);
      idu1_ready = 1'b1;
      step();
      chk("post_flush_drain", 64'(count), 64'd0);

      // asynchronous reset between edges
      idu1_ready = 1'b0;
      drive_addi(4, 200);
      step();
      drive_addi(5, 201);
      step();
      instr_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_valid", 64'(idu0_out_valid), 64'd0);
`ifdef IDU0_Q_PERF_CNT_EN
      chk("rst_perf_decoded", 64'(perf_decoded), 64'd0);
      chk("rst_perf_stall", 64'(perf_stall), 64'd0);
`endif
      sb.delete();
      #3;
      rst = 1'b0;
      step();
      drive_addi(3, 12'h123);
      step();
      instr_valid = 1'b0;
      chk("post_rst_valid", 64'(idu0_out_valid), 64'd1);
      chk("post_rst_count", 64'(count), 64'd1);
      idu1_ready = 1'b1;
      step();

      begin
         int n = 0;
         while (sb.size() != 0 && n < 50) begin
            step();
            n++;
         end
         if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
         end
      end
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
